// File: rtl/fifo_rd_drain.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_drain
// Brief    : Async-FIFO read-side drain with a 2-entry skid buffer feeding a
//            valid/ready stream. Define FIFO_RD_SEQ_CHECK_EN to enable the
//            incrementing-sequence checker on captured words.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_drain #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rd_clk,
  input  logic                  reset,
  input  logic                  empty,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] read_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  word_cnt,
  output logic                  seq_err,
  output logic [CNT_WIDTH-1:0]  err_cnt
);

  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] DATA_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]            occ;
  logic                  inflight;
  logic                  head;
  logic                  tail;
  logic [DATA_WIDTH-1:0] skid_mem [2];
  logic                  pop;
  logic [2:0]            credit;

  assign m_valid = (occ != 2'd0);
  assign pop     = m_valid & m_ready;
  assign m_data  = skid_mem[head];

  // Words already held or on their way must leave room for the one we request;
  // a pop this cycle frees a slot in time for the new word.
  assign credit = {1'b0, occ} + {2'b00, inflight};
  assign rd_en  = !reset && !empty && (credit < (3'd2 + {2'b00, pop}));

  always_ff @(posedge rd_clk) begin
    if (reset) begin
      occ         <= 2'd0;
      inflight    <= 1'b0;
      head        <= 1'b0;
      tail        <= 1'b0;
      skid_mem[0] <= '0;
      skid_mem[1] <= '0;
      word_cnt    <= '0;
    end else begin
      inflight <= rd_en;
      if (inflight) begin
        skid_mem[tail] <= read_data;
        tail           <= ~tail;
      end
      if (pop) begin
        head     <= ~head;
        word_cnt <= word_cnt + CNT_ONE;
      end
      case ({inflight, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

`ifdef FIFO_RD_SEQ_CHECK_EN
  logic [DATA_WIDTH-1:0] expected;
  logic                  seen_first;
  logic                  err_flag;
  logic [CNT_WIDTH-1:0]  err_count;

  // Both match and resync leave expected at word + 1, so one assignment covers both.
  always_ff @(posedge rd_clk) begin
    if (reset) begin
      expected   <= '0;
      seen_first <= 1'b0;
      err_flag   <= 1'b0;
      err_count  <= '0;
    end else if (inflight) begin
      expected   <= read_data + DATA_ONE;
      seen_first <= 1'b1;
      if (seen_first && (read_data != expected)) begin
        err_flag <= 1'b1;
        if (err_count != {CNT_WIDTH{1'b1}}) begin
          err_count <= err_count + CNT_ONE;
        end
      end
    end
  end

  assign seq_err = err_flag;
  assign err_cnt = err_count;
`else
  assign seq_err = 1'b0;
  assign err_cnt = '0;
`endif

endmodule
`default_nettype wire
